// File: rtl/univ_counter_pkg.sv
// univ_counter_pkg: counter mode encoding and terminal-value detection shared by counter slices
package univ_counter_pkg;
  localparam int unsigned MAX_WIDTH = 36;
  typedef enum logic [1:0] {
    CNT_LOAD = 2'b00,
    CNT_INC  = 2'b01,
    CNT_DEC  = 2'b10,
    CNT_HOLD = 2'b11
  } cnt_mode_t;
  // modulus needs one bit more than the widest count to hold 2**MAX_WIDTH
  function automatic logic terminal(
    input logic [MAX_WIDTH:0] q,
    input cnt_mode_t          mode,
    input logic [MAX_WIDTH:0] modulus
  );
    return (mode == CNT_INC && q >= modulus - 1'b1) || (mode == CNT_DEC && q == '0);
  endfunction
endpackage

// File: rtl/univ_counter.sv
// univ_counter: cascadable up/down/load counter with programmable modulus, optional saturation,
// active-low carry chain and registered wrap pulse
module univ_counter
  import univ_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             nCryIn,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             nCryOut,
  output logic             wrap
);
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("univ_counter: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("univ_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end
  localparam logic [WIDTH-1:0] TERM_HI = WIDTH'(MODULUS - 64'd1);
  cnt_mode_t        mode;
  logic             step;
  logic             at_term;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             wrap_d, wrap_q;
  always_comb begin
    mode    = cnt_mode_t'(sel);
    step    = !nCryIn && (mode == CNT_INC || mode == CNT_DEC);
    at_term = terminal((MAX_WIDTH+1)'(cnt_q), mode, (MAX_WIDTH+1)'(MODULUS));
    cnt_d   = clr              ? '0 :
              mode == CNT_LOAD ? d :
              !step            ? cnt_q :
              at_term          ? (SATURATE ? cnt_q : (mode == CNT_INC ? '0 : TERM_HI)) :
              mode == CNT_INC  ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
    wrap_d  = !clr && mode != CNT_LOAD && step && at_term && !SATURATE;
    // LOAD drives carry low so downstream slices behave like the legacy parts
    nCryOut = mode == CNT_LOAD ? 1'b0 : !(step && at_term);
  end
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end
  assign q    = cnt_q;
  assign wrap = wrap_q;
endmodule

// File: doc/univ_counter.md
Name: univ_counter

Overview:
- Parametrised synchronous universal up/down counter; next-generation replacement for the fixed 4-bit ECL counter slices in the datapath (e.g. the loop counters and shift-count registers).
- Generalised to WIDTH bits with a programmable modulus and an optional saturate mode.
- Uses a single real clock (no carry-gated clocking) and an active-low cascade carry, so wide counters are built by chaining instances.
- Adds synchronous clear and a registered wrap indication.

Parameters:
- WIDTH, 4, counter width in bits (1..36).
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal range 2..2**WIDTH; elaboration error otherwise.
- SATURATE, 0, 1 = INC/DEC stop at terminal value instead of wrapping.

Ports:
- clk  in  1  single system clock, all state changes on rising edge.
- nReset  in  1  asynchronous active-low reset.
- d  in  WIDTH  parallel load data.
- sel  in  2  mode: 00 LOAD, 01 INC, 10 DEC, 11 HOLD.
- nCryIn  in  1  active-low count enable / cascade carry-in.
- clr  in  1  synchronous clear, highest synchronous priority.
- q  out  WIDTH  counter value.
- nCryOut  out  1  active-low cascade carry-out (combinational).
- wrap  out  1  registered one-cycle pulse: the last edge wrapped.

Behaviour:
- Reset (nReset=0, asynchronous): q=0, wrap=0 immediately, independent of clk. Release is synchronous to clk. The first active edge after release follows the normal rules.
- Rising-edge priority:
  - clr=1 -> q=0, wrap=0.
  - Else LOAD -> q=d, regardless of nCryIn. d >= MODULUS is loaded unchanged.
  - Else INC with nCryIn=0: if q >= MODULUS-1 (terminal), q=0 (SATURATE=0) or q unchanged (SATURATE=1); otherwise q=q+1.
  - Else DEC with nCryIn=0: if q==0 (terminal), q=MODULUS-1 (SATURATE=0) or q=0 (SATURATE=1); otherwise q=q-1.
  - Else (HOLD, or INC/DEC with nCryIn=1): q unchanged.
- Arithmetic is WIDTH-bit unsigned; no bits beyond WIDTH are kept.
- wrap: set to 1 for exactly one cycle after an edge that took a terminal INC/DEC step with SATURATE=0. Otherwise 0, including on saturate-hold edges.
- nCryOut (combinational, zero latency):
  - LOAD: 0 (asserted), so downstream slices see a carry, matching legacy slice behaviour.
  - INC: 0 when nCryIn=0 and q >= MODULUS-1.
  - DEC: 0 when nCryIn=0 and q==0.
  - HOLD: 1.
  - The nCryIn->nCryOut path is purely combinational so a chain of N instances steps as one N*WIDTH counter in a single cycle.
- nCryOut asserts at terminal in both wrap and saturate modes.
- Simultaneous events:
  - clr beats LOAD and beats any count.
  - An nReset assertion mid-count wins immediately.
  - A change of sel between edges takes effect at the next edge only; nCryOut follows it combinationally.
- No internal state besides q and wrap; no latency beyond one clock from inputs to q.

Decomposition:
- Package univ_counter_pkg:
  - typedef enum logic [1:0] cnt_mode_t {CNT_LOAD=2'b00, CNT_INC=2'b01, CNT_DEC=2'b10, CNT_HOLD=2'b11}.
  - Helper function terminal(q, mode, modulus).
- No sub-module. Terminal detection stays inline; cascading is done by instantiating univ_counter repeatedly at the parent level.

Test Plan:
- Reset: drive q to 5, assert nReset=0 mid-cycle -> q=0 and wrap=0 before the next clk edge; release, then INC with nCryIn=0 -> q=1.
- Wrap INC, WIDTH=4, MODULUS=10: LOAD 8, INC x2 -> q=9 with nCryOut=0, then q=0 with wrap=1 for one cycle; next INC -> q=1, wrap=0.
- Wrap DEC, same configuration: LOAD 0 -> nCryOut=0 in DEC; DEC -> q=9, wrap=1. With SATURATE=1, DEC at 0 -> q stays 0, wrap=0, nCryOut=0.
- Enable and hold: INC with nCryIn=1 for 3 cycles -> q unchanged, nCryOut=1. HOLD with nCryIn=0 -> q unchanged, nCryOut=1.
- Priority: clr=1 with sel=LOAD, d=7 -> q=0. LOAD d=12 with MODULUS=10 -> q=12; INC -> q=0, wrap=1.
- Cascade: two WIDTH=4 instances, low nCryOut feeding high nCryIn, default MODULUS. Load 0x0F, INC -> 0x10 in one cycle. Load 0xFF, INC -> 0x00 and the high slice's nCryOut was 0 before the edge.
